input_handler: RTL and testbench

//   Front-end of the FPGA calculator. Conditions the raw board inputs: 4 data switches,
//   the sw4 lock switch, BTNU (confirm) and BTNL (clear).

---
 rtl/calc_pkg.sv | 12 +
 rtl/button_conditioner.sv | 53 +++++
 rtl/input_handler.sv | 123 ++++++++++++
 tb/tb_input_handler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator front-end.
package calc_pkg;

    localparam int unsigned OPERAND_W = 4;

    typedef enum logic [1:0] {
        WAIT_OP1 = 2'd0,
        WAIT_OP2 = 2'd1,
        DONE     = 2'd2
    } entry_state_t;

endpackage

// File: rtl/button_conditioner.sv
// Raw button to single press pulse: 2-FF synchroniser, debounce counter, rising-edge detect.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on accepted rise.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/input_handler.sv
// Calculator front-end: conditions board inputs and captures two operands in sequence.
module input_handler
    import calc_pkg::*;
#(
    parameter int unsigned OPERAND_W       = calc_pkg::OPERAND_W,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPERAND_W-1:0] sw,
    input  logic                 sw4,
    input  logic                 BTNL,
    input  logic                 BTNU,
    output logic [OPERAND_W-1:0] operand1,
    output logic [OPERAND_W-1:0] operand2,
    output logic                 confirmed_operand1,
    output logic                 confirmed_operand2,
    output logic                 reset
);

    logic [OPERAND_W-1:0] sw_meta_q, sw_sync_q;
    logic                 sw4_meta_q, sw4_sync_q;
    logic                 clear_pulse;
    logic                 confirm_pulse;

    entry_state_t         state_q, state_d;
    logic [OPERAND_W-1:0] op1_q, op1_d;
    logic [OPERAND_W-1:0] op2_q, op2_d;
    logic                 conf1_q, conf1_d;
    logic                 conf2_q, conf2_d;
    logic                 reset_q, reset_d;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (BTNL),
        .press_pulse(clear_pulse)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_confirm (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw        (BTNU),
        .press_pulse(confirm_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            sw4_meta_q <= 1'b0;
            sw4_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= sw;
            sw_sync_q  <= sw_meta_q;
            sw4_meta_q <= sw4;
            sw4_sync_q <= sw4_meta_q;
        end
    end

    // Clear has priority over confirm; the lock switch masks confirm in every state.
    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        conf1_d = conf1_q;
        conf2_d = conf2_q;
        reset_d = 1'b0;
        if (clear_pulse) begin
            state_d = WAIT_OP1;
            op1_d   = '0;
            op2_d   = '0;
            conf1_d = 1'b0;
            conf2_d = 1'b0;
            reset_d = 1'b1;
        end else if (confirm_pulse && !sw4_sync_q) begin
            case (state_q)
                WAIT_OP1: begin
                    op1_d   = sw_sync_q;
                    conf1_d = 1'b1;
                    state_d = WAIT_OP2;
                end
                WAIT_OP2: begin
                    op2_d   = sw_sync_q;
                    conf2_d = 1'b1;
                    state_d = DONE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_OP1;
            op1_q   <= '0;
            op2_q   <= '0;
            conf1_q <= 1'b0;
            conf2_q <= 1'b0;
            reset_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            conf1_q <= conf1_d;
            conf2_q <= conf2_d;
            reset_q <= reset_d;
        end
    end

    assign operand1           = op1_q;
    assign operand2           = op2_q;
    assign confirmed_operand1 = conf1_q;
    assign confirmed_operand2 = conf2_q;
    assign reset              = reset_q;

endmodule

// File: tb/tb_input_handler.sv
// Directed scoreboard bench for input_handler with a short debounce window.
module tb_input_handler;

    localparam int unsigned OW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [OW-1:0] sw = '0;
    logic          sw4 = 1'b0;
    logic          BTNL = 1'b0;
    logic          BTNU = 1'b0;
    logic [OW-1:0] operand1, operand2;
    logic          confirmed_operand1, confirmed_operand2, reset;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;
    int implication_viol = 0;

    typedef struct {
        string         tag;
        logic [OW-1:0] op1;
        logic [OW-1:0] op2;
        logic          c1;
        logic          c2;
        int            pulses;
        int            pulse_base;
    } exp_t;

    exp_t sb[$];

    input_handler #(
        .OPERAND_W      (OW),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sw                (sw),
        .sw4               (sw4),
        .BTNL              (BTNL),
        .BTNU              (BTNU),
        .operand1          (operand1),
        .operand2          (operand2),
        .confirmed_operand1(confirmed_operand1),
        .confirmed_operand2(confirmed_operand2),
        .reset             (reset)
    );

    always #5 clk = ~clk;

    // Count cycles with reset high and any cycle breaking the flag ordering.
    always @(negedge clk) begin
        if (reset === 1'b1) pulse_cnt++;
        if (confirmed_operand2 === 1'b1 && confirmed_operand1 !== 1'b1) implication_viol++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [OW-1:0] op1, input logic [OW-1:0] op2,
                            input logic c1, input logic c2, input int pulses);
        exp_t e;
        e.tag = tag; e.op1 = op1; e.op2 = op2; e.c1 = c1; e.c2 = c2;
        e.pulses = pulses; e.pulse_base = pulse_cnt;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_op1"}, int'(operand1), int'(e.op1));
        chk({e.tag, "_op2"}, int'(operand2), int'(e.op2));
        chk({e.tag, "_conf1"}, int'(confirmed_operand1), int'(e.c1));
        chk({e.tag, "_conf2"}, int'(confirmed_operand2), int'(e.c2));
        chk({e.tag, "_pulses"}, pulse_cnt - e.pulse_base, e.pulses);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic u, input logic l, input int hold);
        BTNU = u;
        BTNL = l;
        idle(hold);
        BTNU = 1'b0;
        BTNL = 1'b0;
        idle(14);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        idle(3);
        chk("in_reset_reset_out", int'(reset), 0);
        rst_n = 1'b1;

        push_exp("power_up", 4'd0, 4'd0, 1'b0, 1'b0, 0);
        idle(10);
        check_front();

        sw = 4'b1010;
        push_exp("capture_op1", 4'd10, 4'd0, 1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 10);
        check_front();

        sw = 4'b0011;
        push_exp("capture_op2", 4'd10, 4'd3, 1'b1, 1'b1, 0);
        press(1'b1, 1'b0, 10);
        check_front();

        sw = 4'b1111;
        push_exp("done_ignores", 4'd10, 4'd3, 1'b1, 1'b1, 0);
        press(1'b1, 1'b0, 10);
        check_front();

        push_exp("clear", 4'd0, 4'd0, 1'b0, 1'b0, 1);
        press(1'b0, 1'b1, 10);
        check_front();

        sw = 4'd5;
        push_exp("after_clear_op1", 4'd5, 4'd0, 1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 10);
        check_front();

        sw = 4'd9;
        push_exp("glitch_2clk", 4'd5, 4'd0, 1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 2);
        check_front();

        push_exp("toggle_3clk", 4'd5, 4'd0, 1'b1, 1'b0, 0);
        BTNU = 1'b1; idle(1);
        BTNU = 1'b0; idle(1);
        BTNU = 1'b1; idle(1);
        BTNU = 1'b0; idle(14);
        check_front();

        sw4 = 1'b1;
        idle(4);
        push_exp("locked", 4'd5, 4'd0, 1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 10);
        check_front();
        sw4 = 1'b0;
        idle(4);

        push_exp("clear_and_confirm", 4'd0, 4'd0, 1'b0, 1'b0, 1);
        press(1'b1, 1'b1, 10);
        check_front();

        sw = 4'd6;
        push_exp("wait_op1_after_tie", 4'd6, 4'd0, 1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 10);
        check_front();

        // Abort a confirm mid-debounce with an async reset.
        sw = 4'd7;
        BTNU = 1'b1;
        idle(4);
        push_exp("async_reset_now", 4'd0, 4'd0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        BTNU = 1'b0;
        #1;
        check_front();
        chk("async_reset_reset_out", int'(reset), 0);
        idle(2);
        rst_n = 1'b1;
        push_exp("after_async_reset", 4'd0, 4'd0, 1'b0, 1'b0, 0);
        idle(15);
        check_front();

        chk("conf2_implies_conf1", implication_viol, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
